hbm_axi_responder: RTL and testbench

//  AXI4 memory-mapped responder (slave) that answers the subset of AXI master channels

---
 rtl/hbm_axi_responder.sv | 152 +++++++++++++++
 tb/tb_hbm_axi_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hbm_axi_responder.sv
// hbm_axi_responder: AXI4 INCR-burst responder backed by a phit-wide memory array
module hbm_axi_responder #(
    parameter int phit_size    = 512,
    parameter int dwidth_aximm = 64,
    parameter int DEPTH        = 256
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [dwidth_aximm-1:0]  s_axi_araddr,
    input  logic [7:0]               s_axi_arlen,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [phit_size-1:0]     s_axi_rdata,
    output logic                     s_axi_rlast,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    input  logic [dwidth_aximm-1:0]  s_axi_awaddr,
    input  logic [7:0]               s_axi_awlen,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [phit_size-1:0]     s_axi_wdata,
    input  logic [phit_size/8-1:0]   s_axi_wstrb,
    input  logic                     s_axi_wlast,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    output logic                     wlast_err
);
    localparam int NB  = phit_size / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [phit_size-1:0] mem [DEPTH];
    r_state_t r_state;
    w_state_t w_state;
    logic [AW-1:0] r_idx, w_idx, ar_idx, aw_idx, r_nxt;
    logic [7:0] r_cnt, r_len, w_cnt, w_len;
    logic w_fire, w_end;
    logic unused_addr;

    assign ar_idx = s_axi_araddr[OFF+AW-1:OFF];
    assign aw_idx = s_axi_awaddr[OFF+AW-1:OFF];
    assign r_nxt  = r_idx + 1'b1;
    assign w_fire = s_axi_wvalid && s_axi_wready;
    assign w_end  = w_cnt == w_len;
    assign unused_addr = ^{s_axi_araddr, s_axi_awaddr};

    // Byte-masked memory write; no reset so contents survive ap_rst_n
    always_ff @(posedge ap_clk) begin
        if (w_fire)
            for (int b = 0; b < NB; b++)
                if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end

    // Read FSM: registered rdata, back-to-back beats, outputs frozen while rready is low
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_len         <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arready && s_axi_arvalid) begin
                        r_state       <= R_BURST;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= mem[ar_idx];
                        s_axi_rlast   <= s_axi_arlen == 8'd0;
                        r_idx         <= ar_idx;
                        r_cnt         <= 8'd0;
                        r_len         <= s_axi_arlen;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                default: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            r_state       <= R_IDLE;
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                        end else begin
                            r_idx       <= r_nxt;
                            r_cnt       <= r_cnt + 8'd1;
                            s_axi_rdata <= mem[r_nxt];
                            s_axi_rlast <= r_cnt + 8'd1 == r_len;
                        end
                    end
                end
            endcase
        end
    end

    // Write FSM: beat count ends the burst, wlast only feeds the sticky error flag
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            wlast_err     <= 1'b0;
            w_idx         <= '0;
            w_cnt         <= '0;
            w_len         <= '0;
        end else begin
            if (w_fire && (s_axi_wlast != w_end)) wlast_err <= 1'b1;
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awready && s_axi_awvalid) begin
                        w_state       <= W_DATA;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_idx         <= aw_idx;
                        w_cnt         <= 8'd0;
                        w_len         <= s_axi_awlen;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt + 8'd1;
                        if (w_end) begin
                            w_state      <= W_RESP;
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (s_axi_bready) begin
                        w_state       <= W_IDLE;
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hbm_axi_responder.sv
// tb_hbm_axi_responder: directed bursts against a byte-strobed memory model
module tb_hbm_axi_responder;
    localparam int PW = 512;
    localparam int NB = 64;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [63:0] araddr, awaddr;
    logic [7:0] arlen, awlen;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, wlast_err;
    logic [PW-1:0] rdata, wdata;
    logic [NB-1:0] wstrb;

    int checks = 0;
    int failures = 0;
    logic [PW-1:0] model [DEPTH];
    logic [PW-1:0] wbuf [DEPTH];

    always #5 clk = ~clk;

    hbm_axi_responder #(.phit_size(PW), .dwidth_aximm(64), .DEPTH(DEPTH)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bvalid(bvalid), .s_axi_bready(bready), .wlast_err(wlast_err)
    );

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pat(input int seed);
        logic [PW-1:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'(seed) * 32'h01000193 + 32'(i);
        return d;
    endfunction

    task automatic chk_reset(input string tag);
        check({tag, "_arready"}, arready, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_rlast"}, rlast, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_awready"}, awready, 0);
        check({tag, "_wready"}, wready, 0);
        check({tag, "_bvalid"}, bvalid, 0);
        check({tag, "_wlast_err"}, wlast_err, 0);
    endtask

    task automatic write_burst(input int word, input int len, input logic [NB-1:0] strb, input int wl_beat);
        int t = 0;
        int beats = 0;
        @(negedge clk);
        awaddr = 64'(word * 64); awlen = 8'(len); awvalid = 1'b1;
        while (!awready && t < 100) begin @(negedge clk); t++; end
        check("aw_ready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        while (beats <= len && t < 1000) begin
            wdata = wbuf[beats]; wstrb = strb; wlast = beats == wl_beat; wvalid = 1'b1;
            if (wready) begin
                for (int b = 0; b < NB; b++)
                    if (strb[b]) model[(word + beats) % DEPTH][b*8 +: 8] = wbuf[beats][b*8 +: 8];
                beats++;
            end
            @(negedge clk); t++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_beats", beats, len + 1);
        check("w_ready_low", wready, 0);
        while (!bvalid && t < 1000) begin @(negedge clk); t++; end
        check("bvalid", bvalid, 1);
        @(negedge clk);
        check("bvalid_once", bvalid, 0);
        check("aw_ready_back", awready, 1);
    endtask

    task automatic read_burst(input int word, input int len, input int mode);
        int t = 0;
        int beat = 0;
        int k = 0;
        logic rr;
        @(negedge clk);
        araddr = 64'(word * 64); arlen = 8'(len); arvalid = 1'b1; rready = 1'b0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        check("ar_ready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_latency", rvalid, 1);
        while (beat <= len && t < 2000) begin
            rr = (mode == 0) || (k % 3 == 0);
            rready = rr;
            check("rvalid", rvalid, 1);
            if (rvalid) begin
                check("rdata", rdata, model[(word + beat) % DEPTH]);
                check("rlast", rlast, beat == len);
                check("ar_low", arready, 0);
                if (rr) beat++;
            end
            @(negedge clk); k++; t++;
        end
        rready = 1'b0;
        check("r_beats", beat, len + 1);
        check("r_end_valid", rvalid, 0);
        check("r_end_arready", arready, 1);
    endtask

    initial begin
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_reset("rst0");
        repeat (3) @(negedge clk);
        chk_reset("rst1");
        rst_n = 1'b1;
        #1 check("arready_not_yet", arready, 0);
        @(negedge clk);
        check("arready_up", arready, 1);
        check("awready_up", awready, 1);

        // basic 4-beat write then read back
        for (int i = 0; i < 4; i++) wbuf[i] = pat(i + 1);
        write_burst(0, 3, '1, 3);
        read_burst(0, 3, 0);
        check("wlast_err_clean", wlast_err, 0);

        // byte strobes: only bytes 0..7 replace an all-ones word
        wbuf[0] = '1;
        write_burst(1, 0, '1, 0);
        wbuf[0] = pat(20);
        write_burst(1, 0, 64'h00000000000000FF, 0);
        read_burst(1, 0, 0);

        // 8-beat read with rready pattern 1,0,0
        for (int i = 0; i < 8; i++) wbuf[i] = pat(30 + i);
        write_burst(0, 7, '1, 7);
        read_burst(0, 7, 1);

        // address wrap plus early wlast
        wbuf[0] = pat(40); wbuf[1] = pat(41);
        write_burst(255, 1, '1, 0);
        check("wlast_err_set", wlast_err, 1);
        read_burst(255, 1, 0);

        // same-cycle read and write of word 5
        wbuf[0] = pat(50);
        write_burst(5, 0, '1, 0);
        @(negedge clk);
        awaddr = 64'(5 * 64); awlen = 8'd0; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("rw_wready", wready, 1);
        check("rw_arready", arready, 1);
        wdata = pat(51); wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
        araddr = 64'(5 * 64); arlen = 8'd0; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        check("rw_rvalid", rvalid, 1);
        check("rw_old_data", rdata, pat(50));
        check("rw_rlast", rlast, 1);
        check("rw_bvalid", bvalid, 1);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rw_rdone", rvalid, 0);
        check("rw_bdone", bvalid, 0);
        model[5] = pat(51);
        read_burst(5, 0, 0);

        // reset in the middle of a read burst and a write burst
        @(negedge clk);
        araddr = '0; arlen = 8'd7; arvalid = 1'b1; rready = 1'b0;
        awaddr = 64'(10 * 64); awlen = 8'd3; awvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0;
        check("mid_rvalid", rvalid, 1);
        check("mid_wready", wready, 1);
        wdata = pat(60); wstrb = '1; wvalid = 1'b1;
        @(negedge clk);
        model[10] = pat(60);
        wdata = pat(61);
        @(negedge clk);
        model[11] = pat(61);
        wvalid = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_arready", arready, 1);
        check("post_awready", awready, 1);
        check("post_rvalid", rvalid, 0);
        read_burst(10, 1, 0);
        for (int i = 0; i < 3; i++) wbuf[i] = pat(70 + i);
        write_burst(20, 2, '1, 2);
        read_burst(20, 2, 0);
        check("post_wlast_err", wlast_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
